collision_manager: RTL and testbench

- Parametrised per-frame collision arbiter between the player sprite and N_OBJ object layers (walls, ropes, fruits, enemies).
- Counts overlapping pixels per object. Declares a hit once an object reaches HIT_THRESH overlapping pixels within one frame.
- Emits one pulse per object per frame, and publishes a stable hit mask and count for the whole following frame.
- Sits between the object drawing-request muxes and the game-logic and score blocks.

---
 rtl/collision_manager.sv | 114 +++++++++++
 tb/tb_collision_manager.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/collision_manager.sv
// Per-frame collision arbiter between the player sprite and N_OBJ object layers.
// Counts overlap pixels per object, pulses once per object per frame, and publishes last frame's hit mask.
module collision_manager #(
    parameter int N_OBJ      = 5,
    parameter int HIT_THRESH = 1,
    parameter int IDX_W      = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    parameter int CNT_W      = $clog2(HIT_THRESH + 1)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               player_req,
    input  logic [N_OBJ-1:0]   obj_req,
    input  logic [N_OBJ-1:0]   obj_enable,
    output logic [N_OBJ-1:0]   hit_pulse,
    output logic               any_hit_pulse,
    output logic               first_hit_valid,
    output logic [IDX_W-1:0]   first_hit_idx,
    output logic [N_OBJ-1:0]   frame_hits,
    output logic [IDX_W:0]     frame_hit_count
);

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    localparam logic [CNT_W-1:0] THR_C = CNT_W'(HIT_THRESH);

    state_t             state;
    logic [CNT_W-1:0]   cnt     [N_OBJ];
    logic [CNT_W-1:0]   cnt_nxt [N_OBJ];
    logic [N_OBJ-1:0]   latch;
    logic [N_OBJ-1:0]   latch_nxt;
    logic [N_OBJ-1:0]   newly;
    logic [N_OBJ-1:0]   hit;
    logic [IDX_W-1:0]   low_idx;
    logic [IDX_W:0]     latch_pop;

    assign hit = {N_OBJ{player_req}} & obj_req & obj_enable;

    // On startOfFrame the counters restart from zero, so a coincident pixel counts for the new frame.
    always_comb begin
        newly = '0;
        latch_nxt = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            logic [CNT_W-1:0] base_cnt;
            logic             base_latch;
            base_cnt   = startOfFrame ? '0 : cnt[i];
            base_latch = startOfFrame ? 1'b0 : latch[i];
            cnt_nxt[i]   = base_cnt;
            latch_nxt[i] = base_latch;
            if (hit[i] && !base_latch) begin
                if (base_cnt == THR_C - 1'b1) begin
                    cnt_nxt[i]   = THR_C;
                    latch_nxt[i] = 1'b1;
                    newly[i]     = 1'b1;
                end else begin
                    cnt_nxt[i] = base_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        low_idx = '0;
        latch_pop = '0;
        for (int unsigned i = 0; i < N_OBJ; i++) begin
            if (newly[i] && !found) begin
                low_idx = IDX_W'(i);
                found   = 1'b1;
            end
            latch_pop = latch_pop + {{IDX_W{1'b0}}, latch[i]};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= WAIT_SOF;
            latch           <= '0;
            hit_pulse       <= '0;
            any_hit_pulse   <= 1'b0;
            first_hit_valid <= 1'b0;
            first_hit_idx   <= '0;
            frame_hits      <= '0;
            frame_hit_count <= '0;
            for (int unsigned i = 0; i < N_OBJ; i++) cnt[i] <= '0;
        end else begin
            case (state)
                WAIT_SOF: begin
                    hit_pulse     <= '0;
                    any_hit_pulse <= 1'b0;
                    if (startOfFrame) state <= ACTIVE;
                end
                ACTIVE: begin
                    latch         <= latch_nxt;
                    for (int unsigned i = 0; i < N_OBJ; i++) cnt[i] <= cnt_nxt[i];
                    hit_pulse     <= newly;
                    any_hit_pulse <= |newly;
                    if (startOfFrame) begin
                        frame_hits      <= latch;
                        frame_hit_count <= latch_pop;
                        first_hit_valid <= |newly;
                        first_hit_idx   <= (|newly) ? low_idx : '0;
                    end else if (!first_hit_valid && (|newly)) begin
                        first_hit_valid <= 1'b1;
                        first_hit_idx   <= low_idx;
                    end
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_manager.sv
// Directed bench for collision_manager: one instance at HIT_THRESH=1, one at HIT_THRESH=4, shared stimulus.
module tb_collision_manager;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       player_req;
    logic [4:0] obj_req;
    logic [4:0] obj_enable;

    logic [4:0] hp1, fh1, hp4, fh4;
    logic       any1, fv1, any4, fv4;
    logic [2:0] fi1, fi4;
    logic [3:0] fc1, fc4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collision_manager #(.N_OBJ(5), .HIT_THRESH(1)) u1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .player_req(player_req),
        .obj_req(obj_req), .obj_enable(obj_enable), .hit_pulse(hp1), .any_hit_pulse(any1),
        .first_hit_valid(fv1), .first_hit_idx(fi1), .frame_hits(fh1), .frame_hit_count(fc1)
    );

    collision_manager #(.N_OBJ(5), .HIT_THRESH(4)) u4 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .player_req(player_req),
        .obj_req(obj_req), .obj_enable(obj_enable), .hit_pulse(hp4), .any_hit_pulse(any4),
        .first_hit_valid(fv4), .first_hit_idx(fi4), .frame_hits(fh4), .frame_hit_count(fc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, let the clock edge take it, then sample just after the edge.
    task automatic cyc(input logic p, input logic [4:0] r, input logic [4:0] en, input logic sof);
        player_req   = p;
        obj_req      = r;
        obj_enable   = en;
        startOfFrame = sof;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        player_req = 1'b0;
        obj_req = '0;
        obj_enable = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pulse", hp1, 5'b00000);
        chk("rst_any", any1, 1'b0);
        chk("rst_valid", fv1, 1'b0);
        chk("rst_idx", fi1, 3'd0);
        chk("rst_fhits", fh1, 5'b00000);
        chk("rst_fcount", fc1, 4'd0);
        resetN = 1'b1;

        // Partial frame after reset is ignored
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 5'b00100, 5'b11111, 1'b0);
            chk("pre_sof_pulse1", hp1, 5'b00000);
            chk("pre_sof_pulse4", hp4, 5'b00000);
        end
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("sof1_fhits", fh1, 5'b00000);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b0);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("sof2_fhits", fh1, 5'b00000);
        chk("sof2_valid", fv1, 1'b0);

        // Basic hit on object 3
        cyc(1'b1, 5'b01000, 5'b11111, 1'b0);
        chk("basic_pulse", hp1, 5'b01000);
        chk("basic_any", any1, 1'b1);
        chk("basic_valid", fv1, 1'b1);
        chk("basic_idx", fi1, 3'd3);
        chk("basic_thr4_pulse", hp4, 5'b00000);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b0);
        chk("basic_pulse_end", hp1, 5'b00000);
        chk("basic_any_end", any1, 1'b0);
        chk("basic_valid_hold", fv1, 1'b1);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("basic_fhits", fh1, 5'b01000);
        chk("basic_fcount", fc1, 4'd1);
        chk("basic_valid_clr", fv1, 1'b0);
        chk("basic_idx_clr", fi1, 3'd0);
        chk("basic_thr4_fhits", fh4, 5'b00000);

        // Threshold 4: frame A gets 3 pixels on obj 0
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 5'b00001, 5'b11111, 1'b0);
            chk("thrA_pulse", hp4, 5'b00000);
            cyc(1'b0, 5'b00000, 5'b11111, 1'b0);
        end
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("thrA_fhits", fh4, 5'b00000);
        chk("thrA_fcount", fc4, 4'd0);
        // Frame B: 4th non-consecutive pixel declares the hit
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 5'b00001, 5'b11111, 1'b0);
            chk("thrB_pulse_pre", hp4, 5'b00000);
            cyc(1'b0, 5'b00000, 5'b11111, 1'b0);
        end
        cyc(1'b1, 5'b00001, 5'b11111, 1'b0);
        chk("thrB_pulse", hp4, 5'b00001);
        chk("thrB_any", any4, 1'b1);
        chk("thrB_valid", fv4, 1'b1);
        chk("thrB_idx", fi4, 3'd0);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b0);
        chk("thrB_pulse_end", hp4, 5'b00000);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 5'b00001, 5'b11111, 1'b0);
            chk("thrB_no_repeat", hp4, 5'b00000);
        end
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("thrB_fhits", fh4, 5'b00001);
        chk("thrB_fcount", fc4, 4'd1);
        chk("thr_u1_fhits", fh1, 5'b00001);

        // Simultaneous hits: objs 1 and 4, then obj 0
        cyc(1'b1, 5'b10010, 5'b11111, 1'b0);
        chk("sim_pulse_a", hp1, 5'b10010);
        chk("sim_idx_a", fi1, 3'd1);
        chk("sim_valid_a", fv1, 1'b1);
        cyc(1'b1, 5'b00001, 5'b11111, 1'b0);
        chk("sim_pulse_b", hp1, 5'b00001);
        chk("sim_idx_b", fi1, 3'd1);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("sim_fhits", fh1, 5'b10011);
        chk("sim_fcount", fc1, 4'd3);

        // Disabled object is ignored; overlap on the startOfFrame pixel belongs to the new frame
        cyc(1'b1, 5'b00100, 5'b11011, 1'b0);
        chk("dis_pulse", hp1, 5'b00000);
        chk("dis_valid", fv1, 1'b0);
        cyc(1'b1, 5'b00100, 5'b11111, 1'b1);
        chk("coinc_fhits", fh1, 5'b00000);
        chk("coinc_fcount", fc1, 4'd0);
        chk("coinc_pulse", hp1, 5'b00100);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b0);
        chk("coinc_pulse_end", hp1, 5'b00000);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("coinc_next_fhits", fh1, 5'b00100);
        chk("coinc_next_fcount", fc1, 4'd1);

        // Async reset mid-frame with all bits published and latches set
        cyc(1'b1, 5'b11111, 5'b11111, 1'b0);
        chk("all_pulse", hp1, 5'b11111);
        cyc(1'b0, 5'b00000, 5'b11111, 1'b1);
        chk("all_fhits", fh1, 5'b11111);
        chk("all_fcount", fc1, 4'd5);
        cyc(1'b1, 5'b00011, 5'b11111, 1'b0);
        chk("pre_rst_pulse", hp1, 5'b00011);
        #2 resetN = 1'b0;
        #1;
        chk("arst_pulse", hp1, 5'b00000);
        chk("arst_any", any1, 1'b0);
        chk("arst_valid", fv1, 1'b0);
        chk("arst_fhits", fh1, 5'b00000);
        chk("arst_fcount", fc1, 4'd0);
        #1 resetN = 1'b1;
        cyc(1'b1, 5'b11111, 5'b11111, 1'b0);
        chk("post_rst_ignore", hp1, 5'b00000);
        cyc(1'b1, 5'b11111, 5'b11111, 1'b1);
        chk("post_rst_sof_ignore", hp1, 5'b00000);
        chk("post_rst_sof_fhits", fh1, 5'b00000);
        cyc(1'b1, 5'b00010, 5'b11111, 1'b0);
        chk("post_rst_armed", hp1, 5'b00010);
        chk("post_rst_idx", fi1, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
